dac_state_loader: RTL and testbench

//  Parametrised serial loader for the current-steering DAC cell array. A serial shift chain is

---
 rtl/dac_state_loader.sv | 181 ++++++++++++++++++
 tb/tb_dac_state_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_state_loader.sv
// Serial shift-chain loader for the current-steering DAC cell array (raw bitmap or thermometer code).
// Optional staircase linearity ramp is built when DAC_RAMP_EN is defined.
module dac_state_loader #(
    parameter int unsigned N_CELLS = 128,
    parameter int unsigned OBS_W   = 8
`ifdef DAC_RAMP_EN
    ,
    parameter int unsigned RAMP_DIV = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               datum_i,
    input  logic               shift_i,
    input  logic               transfer_i,
    input  logic               mode_i,
    input  logic               en_i,
    input  logic               ramp_i,
    output logic [N_CELLS-1:0] state_o,
    output logic [N_CELLS-1:0] stateb_o,
    output logic               en_o,
    output logic [OBS_W-1:0]   chain_obs_o,
    output logic [OBS_W-1:0]   state_obs_o,
    output logic               frame_err_o,
    output logic               busy_o
);

    localparam int unsigned CODE_W = $clog2(N_CELLS + 1);

    logic [N_CELLS-1:0] chain;
    logic [CODE_W-1:0]  cnt;

    logic [N_CELLS-1:0] chain_nxt;
    logic [N_CELLS-1:0] state_nxt;
    logic [CODE_W-1:0]  cnt_nxt;
    logic               err_nxt;
    logic [CODE_W-1:0]  frame_len;
    logic [CODE_W-1:0]  code;
    logic               code_sat;
    logic               ramp_start_c;
    logic               in_ramp_c;
    logic               ramp_step_c;
    logic [CODE_W-1:0]  ramp_code;

    function automatic logic [N_CELLS-1:0] thermo(input logic [CODE_W-1:0] c);
        logic [N_CELLS-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            t[i] = (i < 32'(c));
        end
        return t;
    endfunction

`ifdef DAC_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic {
        IDLE,
        RAMP
    } ramp_state_e;

    ramp_state_e      rstate;
    logic             ramp_q;
    logic [DIV_W-1:0] div_cnt;

    assign ramp_start_c = (rstate == IDLE) && ramp_i && !ramp_q;
    assign in_ramp_c    = (rstate == RAMP);
    assign ramp_step_c  = in_ramp_c && ramp_i && (div_cnt == DIV_W'(RAMP_DIV - 1))
                          && (ramp_code != CODE_W'(N_CELLS));

    // Staircase sequencer: one code step per RAMP_DIV cycles, one extra step held at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate    <= IDLE;
            ramp_q    <= 1'b0;
            ramp_code <= '0;
            div_cnt   <= '0;
            busy_o    <= 1'b0;
        end else begin
            ramp_q <= ramp_i;
            case (rstate)
                IDLE: begin
                    if (ramp_start_c) begin
                        rstate    <= RAMP;
                        ramp_code <= '0;
                        div_cnt   <= '0;
                        busy_o    <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!ramp_i) begin
                        rstate <= IDLE;
                        busy_o <= 1'b0;
                    end else if (div_cnt == DIV_W'(RAMP_DIV - 1)) begin
                        div_cnt <= '0;
                        if (ramp_code == CODE_W'(N_CELLS)) begin
                            rstate <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            ramp_code <= ramp_code + CODE_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    rstate <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_ramp;

    assign unused_ramp  = ramp_i;
    assign ramp_start_c = 1'b0;
    assign in_ramp_c    = 1'b0;
    assign ramp_step_c  = 1'b0;
    assign ramp_code    = '0;
    assign busy_o       = 1'b0;
`endif

    assign frame_len = mode_i ? CODE_W'(CODE_W) : CODE_W'(N_CELLS);
    assign code      = chain[CODE_W-1:0];
    assign code_sat  = (code > CODE_W'(N_CELLS));

    // Transfer has priority over shift; ramp updates override the commit path.
    always_comb begin
        chain_nxt = chain;
        state_nxt = state_o;
        cnt_nxt   = cnt;
        err_nxt   = frame_err_o;
        if (transfer_i) begin
            cnt_nxt = '0;
            if (!in_ramp_c && (cnt == frame_len)) begin
                if (mode_i) begin
                    state_nxt = code_sat ? '1 : thermo(code);
                    err_nxt   = code_sat;
                end else begin
                    state_nxt = chain;
                    err_nxt   = 1'b0;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end else if (shift_i) begin
            chain_nxt = {chain[N_CELLS-2:0], datum_i};
            if (cnt != CODE_W'(N_CELLS)) begin
                cnt_nxt = cnt + CODE_W'(1);
            end
        end
        if (ramp_start_c) begin
            state_nxt = '0;
        end else if (ramp_step_c) begin
            state_nxt = thermo(ramp_code + CODE_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain       <= '0;
            cnt         <= '0;
            state_o     <= '0;
            stateb_o    <= '1;
            frame_err_o <= 1'b0;
            en_o        <= 1'b0;
        end else begin
            chain       <= chain_nxt;
            cnt         <= cnt_nxt;
            state_o     <= state_nxt;
            stateb_o    <= ~state_nxt;
            frame_err_o <= err_nxt;
            en_o        <= en_i && !ramp_start_c;
        end
    end

    assign chain_obs_o = chain[N_CELLS-1 -: OBS_W];
    assign state_obs_o = state_o[N_CELLS-1 -: OBS_W];

endmodule

// File: tb/tb_dac_state_loader.sv
// Randomised bench for dac_state_loader against a frame-level reference model.
// Ramp scenarios are exercised when DAC_RAMP_EN is defined.
module tb_dac_state_loader;

    localparam int N  = 128;
    localparam int CW = 8;
    localparam int OW = 8;
`ifdef DAC_RAMP_EN
    localparam int RDIV = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         datum = 1'b0, shift = 1'b0, transfer = 1'b0, mode = 1'b0, en = 1'b0, ramp = 1'b0;
    logic [N-1:0] state_o, stateb_o;
    logic         en_o, frame_err_o, busy_o;
    logic [OW-1:0] chain_obs_o, state_obs_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [N-1:0] m_chain, m_state;
    int           m_cnt;
    bit           m_err, m_en, m_busy, m_ramp_on, m_ramp_prev;
    int           m_ramp_t;

    dac_state_loader #(
        .N_CELLS(N),
        .OBS_W(OW)
`ifdef DAC_RAMP_EN
        ,
        .RAMP_DIV(RDIV)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .datum_i(datum),
        .shift_i(shift),
        .transfer_i(transfer),
        .mode_i(mode),
        .en_i(en),
        .ramp_i(ramp),
        .state_o(state_o),
        .stateb_o(stateb_o),
        .en_o(en_o),
        .chain_obs_o(chain_obs_o),
        .state_obs_o(state_obs_o),
        .frame_err_o(frame_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] therm(input int c);
        logic [N-1:0] t;
        for (int i = 0; i < N; i++) t[i] = (i < c);
        return t;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit start;
        int len, c;
        if (rst) begin
            m_chain = '0; m_state = '0; m_cnt = 0; m_err = 0; m_en = 0;
            m_busy = 0; m_ramp_on = 0; m_ramp_prev = 0; m_ramp_t = 0;
            return;
        end
        start = 0;
`ifdef DAC_RAMP_EN
        start = !m_ramp_on && ramp && !m_ramp_prev;
`endif
        m_en = en && !start;
        if (transfer) begin
            len = mode ? CW : N;
            if (!m_ramp_on && m_cnt == len) begin
                if (mode) begin
                    c = int'(m_chain[CW-1:0]);
                    if (c > N) begin m_state = '1; m_err = 1; end
                    else begin m_state = therm(c); m_err = 0; end
                end else begin
                    m_state = m_chain; m_err = 0;
                end
            end else begin
                m_err = 1;
            end
            m_cnt = 0;
        end else if (shift) begin
            m_chain = {m_chain[N-2:0], datum};
            m_cnt   = (m_cnt < N) ? m_cnt + 1 : N;
        end
`ifdef DAC_RAMP_EN
        if (start) begin
            m_ramp_on = 1; m_ramp_t = 0; m_state = '0; m_busy = 1;
        end else if (m_ramp_on) begin
            if (!ramp) begin
                m_ramp_on = 0; m_busy = 0;
            end else begin
                m_ramp_t++;
                m_state = therm((m_ramp_t / RDIV > N) ? N : m_ramp_t / RDIV);
                if (m_ramp_t == (N + 1) * RDIV) begin m_ramp_on = 0; m_busy = 0; end
            end
        end
`endif
        m_ramp_prev = ramp;
    endtask

    // One clock: inputs already set, advance model, compare just after the edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("state", state_o, m_state);
        check("stateb", stateb_o, ~m_state);
        check("state_obs", N'(state_obs_o), N'(m_state[N-1 -: OW]));
        check("chain_obs", N'(chain_obs_o), N'(m_chain[N-1 -: OW]));
        check("frame_err", N'(frame_err_o), N'(m_err));
        check("en_o", N'(en_o), N'(m_en));
        check("busy", N'(busy_o), N'(m_busy));
    endtask

    task automatic idle();
        shift = 0; transfer = 0; datum = 0;
        cyc();
    endtask

    task automatic shift_bits(input logic [N-1:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            shift = 1; transfer = 0; datum = v[i];
            cyc();
        end
        shift = 0;
    endtask

    task automatic do_transfer(input logic md);
        mode = md; transfer = 1; shift = 0;
        cyc();
        transfer = 0;
    endtask

    logic [N-1:0] pat, rnd;

    initial begin
        // Reset state
        rst = 1; cyc(); cyc();
        rst = 0; en = 1; idle();
        check("reset_state", state_o, '0);
        check("reset_stateb", stateb_o, '1);
        check("reset_err", N'(frame_err_o), '0);

        // Raw A5 bitmap, MSB first
        for (int b = 0; b < N / 8; b++) pat[b*8 +: 8] = 8'hA5;
        shift_bits(pat, N);
        do_transfer(1'b0);
        check("raw_a5_obs", N'(state_obs_o), N'(8'hA5));
        check("raw_a5_full", state_o, pat);
        idle();

        // Thermometer codes incl. boundaries 0, N, N+1 and 200
        pat = N'(37);  shift_bits(pat, CW); do_transfer(1'b1);
        check("thermo_37", state_o, therm(37));
        check("thermo_37_err", N'(frame_err_o), '0);
        pat = N'(200); shift_bits(pat, CW); do_transfer(1'b1);
        check("thermo_200", state_o, '1);
        check("thermo_200_err", N'(frame_err_o), N'(1));
        pat = N'(0);   shift_bits(pat, CW); do_transfer(1'b1);
        check("thermo_0", state_o, '0);
        pat = N'(N);   shift_bits(pat, CW); do_transfer(1'b1);
        check("thermo_full", state_o, '1);
        check("thermo_full_err", N'(frame_err_o), '0);
        pat = N'(N + 1); shift_bits(pat, CW); do_transfer(1'b1);
        check("thermo_sat_err", N'(frame_err_o), N'(1));

        // Short frame rejected, then full frame recovers
        pat = '0; pat[20] = 1'b1; shift_bits(pat, N); do_transfer(1'b0);
        for (int i = 0; i < N; i += 32) rnd[i +: 32] = $urandom;
        shift_bits(rnd, 100); do_transfer(1'b0);
        check("short_keep", state_o, pat);
        check("short_err", N'(frame_err_o), N'(1));
        shift_bits(rnd, N); do_transfer(1'b0);
        check("full_ok", state_o, rnd);
        check("full_ok_err", N'(frame_err_o), '0);

        // Shift and transfer together: datum dropped
        shift_bits(rnd, 5);
        datum = 1; shift = 1; transfer = 1; mode = 0; cyc();
        transfer = 0; shift = 0; idle();

        // Reset mid-frame clears count: 50 + 78 bits must not form a frame
        shift_bits(rnd, 50);
        rst = 1; cyc(); rst = 0;
        check("rst_mid_state", state_o, '0);
        shift_bits(rnd, 78); do_transfer(1'b0);
        check("rst_mid_reject", N'(frame_err_o), N'(1));
        check("rst_mid_state2", state_o, '0);

        // Randomised frames of both modes, lengths exact or off by a little
        for (int f = 0; f < 40; f++) begin
            int len;
            logic md;
            md = 1'($urandom);
            en = 1'($urandom);
            for (int i = 0; i < N; i += 32) rnd[i +: 32] = $urandom;
            if (md && ($urandom_range(0, 1) == 1)) rnd[CW-1:0] = 8'($urandom_range(0, N));
            len = md ? CW : N;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(0, N + 3);
            shift_bits(rnd, len);
            if ($urandom_range(0, 4) == 0) begin
                datum = 1'($urandom); shift = 1;
            end
            do_transfer(md);
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                en = 1'($urandom); idle();
            end
        end

`ifdef DAC_RAMP_EN
        // Full staircase with transfers rejected mid-ramp
        en = 1;
        ramp = 1; cyc();
        check("ramp_start_en", N'(en_o), '0);
        for (int t = 1; t < (N + 1) * RDIV + 4; t++) begin
            if (t == 30) begin
                shift_bits(rnd, CW); do_transfer(1'b1);
                check("ramp_xfer_err", N'(frame_err_o), N'(1));
                t += CW + 1;
            end
            cyc();
            if (t % 64 == 0 && t <= N * RDIV)
                check("ramp_pop", state_o, therm(t / RDIV));
        end
        check("ramp_done_busy", N'(busy_o), '0);
        check("ramp_done_state", state_o, '1);
        ramp = 0; idle();

        // Abort at step 10 freezes the array
        ramp = 1; cyc();
        repeat (10 * RDIV + 1) cyc();
        ramp = 0; cyc();
        repeat (8) cyc();
        check("ramp_abort", state_o, therm(10));
        check("ramp_abort_busy", N'(busy_o), '0);
`else
        ramp = 1; repeat (20) idle();
        check("no_ramp_busy", N'(busy_o), '0);
        ramp = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
